// File: rtl/c1581_pkg.sv
// rtl/c1581_pkg.sv - shared TX state encodings and default timing for the 1581 fast-serial link
package c1581_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_LOW  = 2'd1,
    FS_HIGH = 2'd2,
    FS_GAP  = 2'd3
  } fs_state_e;

  localparam int unsigned DEF_HALF_CLKS  = 4;
  localparam int unsigned DEF_TX_GAP     = 8;
  localparam int unsigned DEF_RX_TIMEOUT = 1024;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c1581_fastser_rx.sv
// rtl/c1581_fastser_rx.sv - 8520 SP/CNT deserialiser with holding register and idle timeout
module c1581_fastser_rx
  import c1581_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT = DEF_RX_TIMEOUT
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       fsdir,
  input  logic       cia_sp_out,
  input  logic       cia_cnt_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int TW = $clog2(RX_TIMEOUT) + 1;

  logic          cnt_dly_q;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bits_q, bits_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          cnt_edge, cnt_fall;

  assign cnt_edge = cnt_dly_q ^ cia_cnt_out;
  assign cnt_fall = cnt_dly_q & ~cia_cnt_out;

  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    timer_d = timer_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (!fsdir) begin
      bits_d  = '0;
      timer_d = '0;
    end else if (cnt_edge) begin
      timer_d = '0;
      if (cnt_fall) begin
        shift_d = {shift_q[6:0], cia_sp_out};
        bits_d  = bits_q + 3'd1;
        // A byte may land in a register that the consumer is draining this very cycle.
        if (bits_q == 3'd7) begin
          if (!valid_q || rx_ready) begin
            data_d  = {shift_q[6:0], cia_sp_out};
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
    end else if (bits_q == 3'd0) begin
      timer_d = '0;
    end else if (timer_q == TW'(RX_TIMEOUT - 1)) begin
      bits_d  = '0;
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_dly_q <= 1'b1;
      shift_q   <= '0;
      bits_q    <= '0;
      timer_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_dly_q <= cia_cnt_out;
      shift_q   <= shift_d;
      bits_q    <= bits_d;
      timer_q   <= timer_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_overrun = ovr_q;
  assign rx_busy    = (bits_q != 3'd0);

endmodule

// File: rtl/c1581_fastser_link.sv
// rtl/c1581_fastser_link.sv - host-side burst endpoint for the 1581 8520 serial port
module c1581_fastser_link
  import c1581_pkg::*;
#(
  parameter int unsigned HALF_CLKS  = DEF_HALF_CLKS,
  parameter int unsigned TX_GAP     = DEF_TX_GAP,
  parameter int unsigned RX_TIMEOUT = DEF_RX_TIMEOUT
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       fsdir,
  input  logic       cia_sp_out,
  input  logic       cia_cnt_out,
  output logic       cia_sp_in,
  output logic       cia_cnt_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_abort,
  output logic       busy
);

  localparam int TW = $clog2(max_u(HALF_CLKS, TX_GAP)) + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CLKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(TX_GAP - 1);

  fs_state_e     state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sp_q, sp_d;
  logic          cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          abort_q, abort_d;
  logic          rx_busy;

  c1581_fastser_rx #(.RX_TIMEOUT(RX_TIMEOUT)) u_rx (
    .clk        (clk),
    .res_n      (res_n),
    .fsdir      (fsdir),
    .cia_sp_out (cia_sp_out),
    .cia_cnt_out(cia_cnt_out),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .rx_busy    (rx_busy)
  );

  // Line levels are computed for the state being entered so they change on the same edge.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    timer_d = timer_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      FS_IDLE: begin
        sp_d    = 1'b1;
        cnt_d   = 1'b1;
        ready_d = ~fsdir;
        if (tx_valid && ready_q) begin
          byte_d  = tx_data;
          bit_d   = 3'd7;
          timer_d = HALF_LAST;
          state_d = FS_LOW;
          sp_d    = tx_data[7];
          cnt_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      FS_LOW, FS_HIGH: begin
        if (fsdir) begin
          state_d = FS_IDLE;
          timer_d = '0;
          sp_d    = 1'b1;
          cnt_d   = 1'b1;
          abort_d = 1'b1;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (state_q == FS_LOW) begin
          state_d = FS_HIGH;
          cnt_d   = 1'b1;
          timer_d = HALF_LAST;
        end else if (bit_q != 3'd0) begin
          state_d = FS_LOW;
          bit_d   = bit_q - 3'd1;
          sp_d    = byte_q[bit_q - 3'd1];
          cnt_d   = 1'b0;
          timer_d = HALF_LAST;
        end else begin
          state_d = FS_GAP;
          sp_d    = 1'b1;
          cnt_d   = 1'b1;
          timer_d = GAP_LAST;
        end
      end
      FS_GAP: begin
        if (fsdir) begin
          state_d = FS_IDLE;
          timer_d = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = FS_IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= FS_IDLE;
      byte_q  <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      sp_q    <= 1'b1;
      cnt_q   <= 1'b1;
      ready_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      abort_q <= abort_d;
    end
  end

  assign cia_sp_in  = sp_q;
  assign cia_cnt_in = cnt_q;
  assign tx_ready   = ready_q;
  assign tx_abort   = abort_q;
  assign busy       = rx_busy | (state_q != FS_IDLE);

endmodule
